// File: rtl/bb_pkg.sv
// bb_pkg: count-width helper and per-word result record for bit_balancer_stream (up to 64-bit words)
package bb_pkg;
  localparam int MAX_W = 64;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  localparam int MAX_CNT_W = cnt_w(MAX_W);
  typedef struct packed {
    logic [MAX_CNT_W-1:0] ones;
    logic [MAX_CNT_W-1:0] zeros;
    logic                 balanced;
    logic [MAX_W-1:0]     acc;
    logic                 sat;
    logic                 last;
  } bb_result_t;
endpackage

// File: rtl/popcount_tree.sv
// popcount_tree: combinational balanced adder tree counting the 1 bits of in; ports: in[WIDTH] -> count[CNT_W]
module popcount_tree
  import bb_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [CNT_W-1:0] count
);
  localparam int P = 1 << $clog2(WIDTH);
  logic [P-1:0] padded;
  logic [CNT_W-1:0] t [P];
  assign padded = P'(in);
  always_comb begin
    for (int k = 0; k < P; k++) t[k] = CNT_W'(padded[k]);
    for (int s = P / 2; s > 0; s = s / 2)
      for (int k = 0; k < s; k++) t[k] = t[2*k] + t[2*k+1];
    count = t[0];
  end
endmodule

// File: rtl/bit_balancer_stream.sv
// bit_balancer_stream: 2-stage valid/ready pipeline giving per-word ones/zeros/balance and a saturating per-frame ones sum; ports: clk, reset_n, in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_ones/out_zeros/out_balanced/out_acc/out_sat/out_last
module bit_balancer_stream
  import bb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_ones,
  output logic [CNT_W-1:0] out_zeros,
  output logic             out_balanced,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             out_last
);
  logic s1_valid, s1_last, s2_valid, s2_adv, s1_adv, sat_q, ovf;
  logic [WIDTH-1:0] s1_data;
  logic [CNT_W-1:0] ones;
  logic [ACC_W-1:0] acc_q, acc_nxt;
  logic [ACC_W:0] sum;
  popcount_tree #(.WIDTH(WIDTH)) u_pop (.in(s1_data), .count(ones));
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign in_ready = reset_n && (!s1_valid || s1_adv);
  assign out_valid = s2_valid;
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(ones);
  assign ovf = sum[ACC_W];
  assign acc_nxt = ovf ? '1 : sum[ACC_W-1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_last <= 1'b0;
      s2_valid <= 1'b0;
      out_ones <= '0;
      out_zeros <= '0;
      out_balanced <= 1'b0;
      out_acc <= '0;
      out_sat <= 1'b0;
      out_last <= 1'b0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) {s1_data, s1_last} <= {in_data, in_last};
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        out_ones <= ones;
        out_zeros <= CNT_W'(WIDTH) - ones;
        out_balanced <= {ones, 1'b0} == (CNT_W+1)'(WIDTH);
        out_acc <= acc_nxt;
        out_sat <= sat_q || ovf;
        out_last <= s1_last;
        // a frame-closing word leaves a zero base so the next word starts a new frame
        acc_q <= s1_last ? '0 : acc_nxt;
        sat_q <= !s1_last && (sat_q || ovf);
      end
    end
  end
endmodule

// File: tb/tb_bit_balancer_stream.sv
// tb_bit_balancer_stream: randomized and directed checks of bit_balancer_stream against a frame-sum reference model
`timescale 1ns/1ps
module tb_bit_balancer_stream;
  import bb_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic m_iv = 0, m_ir, m_il = 0, m_ov, m_or = 0, m_bal, m_sat, m_last;
  logic [7:0] m_id = 0;
  logic [3:0] m_ones, m_zeros;
  logic [15:0] m_acc;
  logic s_iv = 0, s_ir, s_il = 0, s_ov, s_or = 0, s_bal, s_sat, s_last;
  logic [7:0] s_id = 0;
  logic [3:0] s_ones, s_zeros, s_acc;
  logic o_iv = 0, o_ir, o_il = 0, o_ov, o_or = 0, o_bal, o_sat, o_last;
  logic [6:0] o_id = 0;
  logic [2:0] o_ones, o_zeros;
  logic [15:0] o_acc;
  bit_balancer_stream #(.WIDTH(8), .ACC_W(16)) dut_main (
    .clk(clk), .reset_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_id), .in_last(m_il),
    .out_valid(m_ov), .out_ready(m_or), .out_ones(m_ones), .out_zeros(m_zeros), .out_balanced(m_bal),
    .out_acc(m_acc), .out_sat(m_sat), .out_last(m_last));
  bit_balancer_stream #(.WIDTH(8), .ACC_W(4)) dut_sat (
    .clk(clk), .reset_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id), .in_last(s_il),
    .out_valid(s_ov), .out_ready(s_or), .out_ones(s_ones), .out_zeros(s_zeros), .out_balanced(s_bal),
    .out_acc(s_acc), .out_sat(s_sat), .out_last(s_last));
  bit_balancer_stream #(.WIDTH(7), .ACC_W(16)) dut_odd (
    .clk(clk), .reset_n(rst_n), .in_valid(o_iv), .in_ready(o_ir), .in_data(o_id), .in_last(o_il),
    .out_valid(o_ov), .out_ready(o_or), .out_ones(o_ones), .out_zeros(o_zeros), .out_balanced(o_bal),
    .out_acc(o_acc), .out_sat(o_sat), .out_last(o_last));

  typedef struct {bb_result_t r; int stamp;} pend_t;
  pend_t q[$];
  longint unsigned fr_acc[3];
  bit fr_sat[3];
  int errors = 0, checks = 0, cyc = 0, n_acc = 0;
  bit lat_chk = 0, held = 0;
  bb_result_t prev;

  function automatic bb_result_t mk(logic [63:0] ones, logic [63:0] zeros, logic [63:0] acc,
                                    logic bal, logic sat, logic last);
    bb_result_t r;
    r.ones = ones[MAX_CNT_W-1:0];
    r.zeros = zeros[MAX_CNT_W-1:0];
    r.balanced = bal;
    r.acc = acc;
    r.sat = sat;
    r.last = last;
    return r;
  endfunction

  // frame model: count ones, clamp the running frame sum, sticky sat until the frame ends
  function automatic bb_result_t predict(int k, int w, int aw, logic [63:0] d, logic l);
    longint unsigned mx = (64'd1 << aw) - 1;
    longint unsigned sum, acc;
    int n = $countones(d);
    bit sat;
    sum = fr_acc[k] + longint'(n);
    acc = sum > mx ? mx : sum;
    sat = fr_sat[k] || sum > mx;
    fr_acc[k] = l ? 0 : acc;
    fr_sat[k] = !l && sat;
    return mk(64'(n), 64'(w - n), acc, 2 * n == w, sat, l);
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int k = 0; k < 3; k++) begin
      fr_acc[k] = 0;
      fr_sat[k] = 0;
    end
    held = 0;
  endfunction

  task automatic step(input logic iv, input logic [7:0] d, input logic l, input logic ordy);
    bb_result_t got;
    pend_t p;
    m_iv = iv; m_id = d; m_il = l; m_or = ordy;
    #1;
    got = mk(64'(m_ones), 64'(m_zeros), 64'(m_acc), m_bal, m_sat, m_last);
    if (held) begin
      checks++;
      if (got !== prev || m_ov !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%h valid=%b need=%h valid=1", cyc, got, m_ov, prev);
      end
    end
    if (m_ov && ordy) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out cyc=%0d got=%h need=no word", cyc, got);
      end else begin
        if (got !== q[0].r) begin
          errors++;
          $display("FAIL out_word cyc=%0d got=%h need=%h", cyc, got, q[0].r);
        end
        if (lat_chk) begin
          checks++;
          if (cyc != q[0].stamp + 2) begin
            errors++;
            $display("FAIL latency got cycle %0d need cycle %0d", cyc, q[0].stamp + 2);
          end
        end
        void'(q.pop_front());
      end
    end else if (lat_chk && q.size() > 0 && cyc == q[0].stamp + 2) begin
      checks++;
      errors++;
      $display("FAIL latency_missing cyc=%0d got valid=%b need valid=1", cyc, m_ov);
    end
    if (iv && m_ir) begin
      p.r = predict(0, 8, 16, 64'(d), l);
      p.stamp = cyc;
      q.push_back(p);
      n_acc++;
    end
    held = m_ov && !ordy;
    prev = got;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      step(0, 8'h00, 0, 1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d words left need 0", q.size());
      q.delete();
    end
    repeat (2) step(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset;
    bb_result_t got;
    rst_n = 0;
    m_iv = 1; m_or = 1;
    repeat (2) @(negedge clk);
    #1;
    got = mk(64'(m_ones), 64'(m_zeros), 64'(m_acc), m_bal, m_sat, m_last);
    checks++;
    if (m_ir !== 1'b0 || m_ov !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b out=%h need 0 0 0", m_ir, m_ov, got);
    end
    checks++;
    if (s_ov !== 1'b0 || o_ov !== 1'b0 || s_ir !== 1'b0 || o_ir !== 1'b0) begin
      errors++;
      $display("FAIL reset_others got %b%b%b%b need 0000", s_ov, o_ov, s_ir, o_ir);
    end
    m_iv = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (m_ir !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b need 1", m_ir);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    lat_chk = 1;
    step(1, 8'hFF, 0, 1);
    step(1, 8'h0F, 0, 1);
    step(1, 8'h00, 1, 1);
    drain();
  endtask

  task automatic test_frame_boundary;
    lat_chk = 1;
    step(1, 8'h01, 1, 1);
    step(1, 8'h03, 0, 1);
    step(1, 8'h80, 1, 1);
    drain();
  endtask

  task automatic test_back_to_back;
    int a = n_acc;
    lat_chk = 1;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), i == 15, 1);
    checks++;
    if (n_acc - a != 16) begin
      errors++;
      $display("FAIL throughput got %0d accepted need 16", n_acc - a);
    end
    drain();
  endtask

  task automatic test_backpressure;
    int a = n_acc;
    lat_chk = 0;
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
    #1;
    checks++;
    if (n_acc - a != 2 || m_ir !== 1'b0) begin
      errors++;
      $display("FAIL backpressure got accepted=%0d ready=%b need accepted=2 ready=0", n_acc - a, m_ir);
    end
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), i == 3, 1);
    drain();
  endtask

  task automatic test_random;
    lat_chk = 0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    drain();
  endtask

  task automatic test_reset_midframe;
    bb_result_t got;
    lat_chk = 0;
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    rst_n = 0;
    #1;
    got = mk(64'(m_ones), 64'(m_zeros), 64'(m_acc), m_bal, m_sat, m_last);
    checks++;
    if (m_ir !== 1'b0 || m_ov !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset_midframe got ready=%b valid=%b out=%h need 0 0 0", m_ir, m_ov, got);
    end
    m_iv = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (3) step(0, 8'h00, 0, 1);
    lat_chk = 1;
    step(1, 8'h07, 0, 1);
    step(1, 8'h30, 1, 1);
    drain();
  endtask

  task automatic test_saturation;
    logic [7:0] w[12];
    logic l[12];
    bb_result_t e[12], got;
    logic [4:0] tbl[4] = '{{4'd8, 1'b0}, {4'd15, 1'b1}, {4'd15, 1'b1}, {4'd8, 1'b0}};
    w[0] = 8'hFF; w[1] = 8'hFF; w[2] = 8'h01; w[3] = 8'hFF;
    l[0] = 0; l[1] = 0; l[2] = 1; l[3] = 1;
    for (int i = 4; i < 12; i++) begin
      w[i] = 8'($urandom);
      l[i] = i == 11 || $urandom_range(0, 3) == 0;
    end
    for (int i = 0; i < 12; i++) e[i] = predict(1, 8, 4, 64'(w[i]), l[i]);
    for (int i = 0; i < 14; i++) begin
      s_iv = i < 12; s_id = i < 12 ? w[i] : 8'h00; s_il = i < 12 ? l[i] : 1'b0; s_or = 1;
      #1;
      if (i >= 2) begin
        got = mk(64'(s_ones), 64'(s_zeros), 64'(s_acc), s_bal, s_sat, s_last);
        checks++;
        if (s_ov !== 1'b1 || got !== e[i-2]) begin
          errors++;
          $display("FAIL sat_word%0d got valid=%b out=%h need valid=1 out=%h", i - 2, s_ov, got, e[i-2]);
        end
        if (i < 6) begin
          checks++;
          if ({s_acc, s_sat} !== tbl[i-2]) begin
            errors++;
            $display("FAIL sat_acc%0d got acc=%0d sat=%b need acc=%0d sat=%b", i - 2, s_acc, s_sat,
                     tbl[i-2][4:1], tbl[i-2][0]);
          end
        end
      end
      @(negedge clk);
    end
    s_iv = 0;
  endtask

  task automatic test_odd_width;
    logic [6:0] w[12];
    logic l[12];
    bb_result_t e[12], got;
    logic [5:0] tbl[2] = '{{3'd7, 3'd0}, {3'd3, 3'd4}};
    w[0] = 7'h7F; w[1] = 7'h07;
    l[0] = 0; l[1] = 1;
    for (int i = 2; i < 12; i++) begin
      w[i] = 7'($urandom);
      l[i] = i == 11 || $urandom_range(0, 3) == 0;
    end
    for (int i = 0; i < 12; i++) e[i] = predict(2, 7, 16, 64'(w[i]), l[i]);
    for (int i = 0; i < 14; i++) begin
      o_iv = i < 12; o_id = i < 12 ? w[i] : 7'h00; o_il = i < 12 ? l[i] : 1'b0; o_or = 1;
      #1;
      if (i >= 2) begin
        got = mk(64'(o_ones), 64'(o_zeros), 64'(o_acc), o_bal, o_sat, o_last);
        checks++;
        if (o_ov !== 1'b1 || got !== e[i-2] || o_bal !== 1'b0) begin
          errors++;
          $display("FAIL odd_word%0d got valid=%b out=%h need valid=1 out=%h", i - 2, o_ov, got, e[i-2]);
        end
        if (i < 4) begin
          checks++;
          if ({o_ones, o_zeros} !== tbl[i-2]) begin
            errors++;
            $display("FAIL odd_counts%0d got ones=%0d zeros=%0d need ones=%0d zeros=%0d", i - 2, o_ones,
                     o_zeros, tbl[i-2][5:3], tbl[i-2][2:0]);
          end
        end
      end
      @(negedge clk);
    end
    o_iv = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_frame_boundary();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_saturation();
    test_odd_width();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
